// File: rtl/datamem_pkg.sv
// Shared types and helpers for the pipelined data memory.
//   SZ_B/SZ_H/SZ_W/SZ_D : transfer-size encodings (bytes)
//   dmem_rsp_t           : one response record as carried by the pipe and FIFO
//   dmem_fault()         : misalignment / bad-size / out-of-bounds detection
package datamem_pkg;

   // Widest configuration supported; narrower builds use the low bits.
   localparam int MAX_DATA_W = 64;
   localparam int MAX_TAG_W  = 16;

   localparam logic [3:0] SZ_B = 4'd1;
   localparam logic [3:0] SZ_H = 4'd2;
   localparam logic [3:0] SZ_W = 4'd4;
   localparam logic [3:0] SZ_D = 4'd8;

   typedef struct packed {
      logic [MAX_DATA_W-1:0] rdata;
      logic [MAX_TAG_W-1:0]  tag;
      logic                  write;
      logic                  err;
   } dmem_rsp_t;

   // Size must be one of 1/2/4/8, addr a multiple of size and the access
   // must end within the array. The data-width size limit is applied by the
   // caller because it depends on the instance parameter.
   function automatic logic dmem_fault(input logic [31:0] addr,
                                       input logic [3:0]  size,
                                       input logic [31:0] base,
                                       input logic [32:0] bytes);
      logic [31:0] off;
      logic [32:0] end_a;
      logic        bad_sz;
      logic        misal;
      bad_sz = !(size == SZ_B || size == SZ_H || size == SZ_W || size == SZ_D);
      misal  = (addr & ({28'd0, size} - 32'd1)) != 32'd0;
      off    = addr - base;
      end_a  = {1'b0, off} + {29'd0, size};
      return bad_sz || misal || (end_a > bytes);
   endfunction

endpackage

// File: rtl/dmem_rsp_fifo.sv
// Response FIFO for datamem_pipe: DEPTH entries of dmem_rsp_t, first-word
// fall-through (head_o valid whenever empty_o is low).
//   clk, rst_n   : clock, asynchronous active-low reset (pointers/count only)
//   push_i       : write push_data_i (accepted when not full or popping)
//   pop_i        : drop the head entry (ignored when empty)
//   head_o       : oldest entry
//   full_o       : DEPTH entries held
//   empty_o      : no entries held
module dmem_rsp_fifo
   import datamem_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      push_i,
   input  dmem_rsp_t push_data_i,
   input  logic      pop_i,
   output dmem_rsp_t head_o,
   output logic      full_o,
   output logic      empty_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   dmem_rsp_t       mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   // A full FIFO may still take a push on the same edge as a pop.
   assign do_push = push_i && (!full_o || pop_i);
   assign do_pop  = pop_i && !empty_o;
   assign head_o  = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (do_pop && !do_push) count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/datamem_pipe.sv
// Pipelined data memory for the load/store unit.
// Requests (valid/ready) access a little-endian byte array at the accept
// edge; responses come back in order, RD_LAT cycles later, through a
// RSP_DEPTH-entry FIFO guarded by a credit counter.
//   clk, rst_n              : clock, asynchronous active-low reset
//   req_valid/req_ready     : request handshake
//   req_write, req_addr, req_size, req_signed, req_wdata, req_tag
//   rsp_valid/rsp_ready     : response handshake
//   rsp_rdata, rsp_tag, rsp_write, rsp_err
// Build option DATAMEM_CHECK_EN: when defined, misaligned, badly sized and
// out-of-range requests fault (no write, rsp_err=1, rsp_rdata=0). When
// undefined, rsp_err is 0 and addresses wrap and are size-aligned.
module datamem_pipe
   import datamem_pkg::*;
#(
   parameter int          DATA_W    = 32,
   parameter int          MEM_BYTES = 32768,
   parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
   parameter int          RD_LAT    = 2,
   parameter int          TAG_W     = 4,
   parameter int          RSP_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [31:0]       req_addr,
   input  logic [3:0]        req_size,
   input  logic              req_signed,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [TAG_W-1:0]  req_tag,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [TAG_W-1:0]  rsp_tag,
   output logic              rsp_write,
   output logic              rsp_err
);

   localparam int NB = DATA_W / 8;
   localparam int AW = $clog2(MEM_BYTES);
   localparam int CW = $clog2(RSP_DEPTH + 1);

   function automatic logic [3:0] eff_size(input logic [3:0] s);
      case (s)
         SZ_B, SZ_H, SZ_W: return s;
         SZ_D:             return (NB == 8) ? SZ_D : 4'(NB);
         default:          return 4'(NB);
      endcase
   endfunction

   function automatic logic [DATA_W-1:0] extend_load(input logic [DATA_W-1:0] raw,
                                                     input logic [3:0]        sz,
                                                     input logic              sgn);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic signed [31:0] w;
      logic [DATA_W-1:0]  res;
      b = raw[7:0];
      h = raw[15:0];
      w = raw[31:0];
      case (sz)
         SZ_B:    res = sgn ? DATA_W'(b) : DATA_W'(raw[7:0]);
         SZ_H:    res = sgn ? DATA_W'(h) : DATA_W'(raw[15:0]);
         SZ_W:    res = sgn ? DATA_W'(w) : DATA_W'(raw[31:0]);
         default: res = raw;
      endcase
      return res;
   endfunction

   logic [7:0]        mem [MEM_BYTES];
   logic              rst_done_q;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              accept, rsp_hs, fault;
   logic [3:0]        sz;
   logic [AW-1:0]     off, off_al;
   logic [DATA_W-1:0] raw, ld_data;
   dmem_rsp_t         rsp_p0_d;
   logic              push;
   dmem_rsp_t         push_data, head;
   logic              fifo_full, fifo_empty;
   logic              rsp_unused;

   // ---- stage 0: decode, array access at the accept edge ----
   assign sz     = eff_size(req_size);
   assign off    = AW'(req_addr - BASE_ADDR);
   assign off_al = off & ~(AW'(sz) - AW'(1));

`ifdef DATAMEM_CHECK_EN
   assign fault = dmem_fault(req_addr, req_size, BASE_ADDR, 33'(MEM_BYTES)) ||
                  (req_size > 4'(NB));
`else
   assign fault = 1'b0;
`endif

   // Ready is held low until the first edge after reset release. When all
   // credits are used, a response leaving on this edge frees one, so the
   // port still sustains one request per cycle.
   assign rsp_hs    = rsp_valid && rsp_ready;
   assign req_ready = rst_done_q && ((cnt_q < CW'(RSP_DEPTH)) || rsp_hs);
   assign accept    = req_valid && req_ready;

   always_comb begin
      raw = '0;
      for (int i = 0; i < NB; i++)
         if (i < int'(sz)) raw[8*i +: 8] = mem[off_al + AW'(i)];
   end

   assign ld_data = extend_load(raw, sz, req_signed);

   always_comb begin
      rsp_p0_d       = '0;
      rsp_p0_d.rdata = (req_write || fault) ? '0 : MAX_DATA_W'(ld_data);
      rsp_p0_d.tag   = MAX_TAG_W'(req_tag);
      rsp_p0_d.write = req_write;
      rsp_p0_d.err   = fault;
   end

   // Nonblocking write: a load on the same edge reads the old bytes.
   always_ff @(posedge clk) begin
      if (accept && req_write && !fault)
         for (int i = 0; i < NB; i++)
            if (i < int'(sz)) mem[off_al + AW'(i)] <= req_wdata[8*i +: 8];
   end

   // ---- stages 1..RD_LAT-1: fixed-latency delay into the FIFO ----
   generate
      if (RD_LAT == 1) begin : g_direct
         assign push      = accept;
         assign push_data = rsp_p0_d;
      end else begin : g_pipe
         dmem_rsp_t             stg_q [RD_LAT-1];
         logic [RD_LAT-2:0]     vld_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               vld_q <= '0;
            end else begin
               vld_q[0] <= accept;
               for (int i = 1; i < RD_LAT - 1; i++) vld_q[i] <= vld_q[i-1];
            end
         end

         always_ff @(posedge clk) begin
            stg_q[0] <= rsp_p0_d;
            for (int i = 1; i < RD_LAT - 1; i++) stg_q[i] <= stg_q[i-1];
         end

         assign push      = vld_q[RD_LAT-2];
         assign push_data = stg_q[RD_LAT-2];
      end
   endgenerate

   // ---- response FIFO and credit counter ----
   dmem_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (push),
      .push_data_i (push_data),
      .pop_i       (rsp_hs),
      .head_o      (head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   always_comb begin
      cnt_d = cnt_q;
      case ({accept, rsp_hs})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         rst_done_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         rst_done_q <= 1'b1;
      end
   end

   // Outputs read as zero whenever nothing is pending (including reset).
   assign rsp_valid = !fifo_empty;
   assign rsp_rdata = fifo_empty ? '0   : head.rdata[DATA_W-1:0];
   assign rsp_tag   = fifo_empty ? '0   : head.tag[TAG_W-1:0];
   assign rsp_write = fifo_empty ? 1'b0 : head.write;
   assign rsp_err   = fifo_empty ? 1'b0 : head.err;

   assign rsp_unused = ^{head.rdata, head.tag, fifo_full};

endmodule

// File: tb/tb_datamem_pipe.sv
module tb_datamem_pipe;

   localparam int DATA_W    = 32;
   localparam int TAG_W     = 4;
   localparam int RD_LAT    = 2;
   localparam int RSP_DEPTH = 4;

   logic              clk;
   logic              rst_n;
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [31:0]       req_addr;
   logic [3:0]        req_size;
   logic              req_signed;
   logic [DATA_W-1:0] req_wdata;
   logic [TAG_W-1:0]  req_tag;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic [TAG_W-1:0]  rsp_tag;
   logic              rsp_write;
   logic              rsp_err;

   datamem_pipe #(
      .DATA_W    (DATA_W),
      .MEM_BYTES (32768),
      .BASE_ADDR (32'h8000_0000),
      .RD_LAT    (RD_LAT),
      .TAG_W     (TAG_W),
      .RSP_DEPTH (RSP_DEPTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_wdata  (req_wdata),
      .req_tag    (req_tag),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_tag    (rsp_tag),
      .rsp_write  (rsp_write),
      .rsp_err    (rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [3:0]  size;
      bit          sgn;
      logic [31:0] wdata;
      logic [3:0]  tag;
      logic [31:0] exp_rdata;
      bit          exp_wr;
      bit          exp_err;
   } vec_t;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", nm, got, exp);
      end
   endtask

   function automatic vec_t mk(bit wr, logic [31:0] a, logic [3:0] s, bit sg,
                               logic [31:0] wd, logic [3:0] t, logic [31:0] er, bit ee);
      vec_t v;
      v.wr = wr; v.addr = a; v.size = s; v.sgn = sg; v.wdata = wd; v.tag = t;
      v.exp_rdata = er; v.exp_wr = wr; v.exp_err = ee;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      req_write  = v.wr;
      req_addr   = v.addr;
      req_size   = v.size;
      req_signed = v.sgn;
      req_wdata  = v.wdata;
      req_tag    = v.tag;
   endtask

   // Returns just after the accept edge; ok=0 if never accepted.
   task automatic send(input vec_t v, output bit ok);
      @(posedge clk); #1;
      drive(v);
      req_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (req_ready) ok = 1'b1;
         @(posedge clk); #1;
         if (ok) break;
      end
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!rsp_valid && lat < 20);
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout reached at %0t", $time);
      $fatal(1, "timeout");
   end

   vec_t tbl [17];
   vec_t v;
   bit   ok;
   int   lat, k, n, e;
   bit   acc;
   logic [3:0]  got_tag [6];
   int          got_cyc [6];
   logic [31:0] got_dat [6];

   initial begin
      tbl[0]  = mk(1, 32'h8000_0010, 4, 0, 32'hDEAD_BEEF, 4'd1,  32'h0,         0);
      tbl[1]  = mk(0, 32'h8000_0013, 1, 1, 32'h0,         4'd2,  32'hFFFF_FFDE, 0);
      tbl[2]  = mk(0, 32'h8000_0013, 1, 0, 32'h0,         4'd3,  32'h0000_00DE, 0);
      tbl[3]  = mk(0, 32'h8000_0010, 2, 1, 32'h0,         4'd4,  32'hFFFF_BEEF, 0);
      tbl[4]  = mk(0, 32'h8000_0012, 2, 0, 32'h0,         4'd5,  32'h0000_DEAD, 0);
      tbl[5]  = mk(0, 32'h8000_0010, 4, 0, 32'h0,         4'd6,  32'hDEAD_BEEF, 0);
      tbl[6]  = mk(1, 32'h8000_0011, 1, 0, 32'h0000_007F, 4'd7,  32'h0,         0);
      tbl[7]  = mk(0, 32'h8000_0010, 4, 0, 32'h0,         4'd8,  32'hDEAD_7FEF, 0);
      tbl[8]  = mk(0, 32'h8000_0011, 1, 1, 32'h0,         4'd9,  32'h0000_007F, 0);
      tbl[9]  = mk(1, 32'h8000_0020, 4, 0, 32'h0,         4'd10, 32'h0,         0);
      tbl[10] = mk(1, 32'h8000_0022, 2, 0, 32'h0000_8001, 4'd11, 32'h0,         0);
      tbl[11] = mk(0, 32'h8000_0022, 2, 1, 32'h0,         4'd12, 32'hFFFF_8001, 0);
      tbl[12] = mk(0, 32'h8000_0020, 4, 0, 32'h0,         4'd13, 32'h8001_0000, 0);
      tbl[13] = mk(1, 32'h8000_0000, 4, 0, 32'h1122_3344, 4'd14, 32'h0,         0);
`ifdef DATAMEM_CHECK_EN
      tbl[14] = mk(0, 32'h8000_0002, 4, 0, 32'h0,         4'd15, 32'h0,         1);
      tbl[15] = mk(1, 32'h8000_8000, 4, 0, 32'hCAFE_F00D, 4'd0,  32'h0,         1);
      tbl[16] = mk(0, 32'h8000_0000, 4, 0, 32'h0,         4'd1,  32'h1122_3344, 0);
`else
      tbl[14] = mk(0, 32'h8000_0002, 4, 0, 32'h0,         4'd15, 32'h1122_3344, 0);
      tbl[15] = mk(1, 32'h8000_8000, 4, 0, 32'hCAFE_F00D, 4'd0,  32'h0,         0);
      tbl[16] = mk(0, 32'h8000_0000, 4, 0, 32'h0,         4'd1,  32'hCAFE_F00D, 0);
`endif

      // Reset held with a request pending
      rst_n = 1'b0;
      drive(mk(0, 32'h8000_0010, 4, 0, 32'h0, 4'd9, 32'h0, 0));
      req_valid = 1'b1;
      rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_rsp_tag",   rsp_tag,   0);
      chk("rst_rsp_write", rsp_write, 0);
      chk("rst_rsp_err",   rsp_err,   0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      rst_n     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rel_req_ready", req_ready, 1);
      chk("rel_rsp_valid", rsp_valid, 0);

      // Table-driven single transactions
      for (int i = 0; i < 17; i++) begin
         send(tbl[i], ok);
         chk($sformatf("v%0d_accept", i), ok, 1);
         if (ok) begin
            wait_rsp(lat);
            chk($sformatf("v%0d_latency", i), lat,       RD_LAT);
            chk($sformatf("v%0d_rdata", i),   rsp_rdata, tbl[i].exp_rdata);
            chk($sformatf("v%0d_tag", i),     rsp_tag,   tbl[i].tag);
            chk($sformatf("v%0d_write", i),   rsp_write, tbl[i].exp_wr);
            chk($sformatf("v%0d_err", i),     rsp_err,   tbl[i].exp_err);
         end
      end

      // Back-pressure: six loads with rsp_ready low, then drain
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      drive(mk(0, 32'h8000_0010, 4, 0, 32'h0, 4'd0, 32'h0, 0));
      k = 0;
      for (int c = 0; c < 10; c++) begin
         req_valid = 1'b1;
         req_tag   = 4'(k);
         @(negedge clk);
         acc = req_ready;
         @(posedge clk); #1;
         if (acc) k++;
      end
      @(negedge clk);
      chk("bp_accepts",  k,         4);
      chk("bp_ready",    req_ready, 0);
      chk("bp_hold_vld", rsp_valid, 1);
      chk("bp_hold_tag", rsp_tag,   0);
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      n = 0;
      for (int c = 0; c < 30 && n < 6; c++) begin
         req_tag   = 4'(k);
         req_valid = (k < 6);
         @(negedge clk);
         if (rsp_valid) begin
            got_tag[n] = rsp_tag;
            got_cyc[n] = c;
            got_dat[n] = rsp_rdata;
            n++;
         end
         acc = req_valid && req_ready;
         @(posedge clk); #1;
         if (acc) k++;
      end
      req_valid = 1'b0;
      chk("bp_count",   n, 6);
      chk("bp_issued",  k, 6);
      for (int i = 0; i < n; i++) begin
         chk($sformatf("bp_tag%0d", i),  got_tag[i],             4'(i));
         chk($sformatf("bp_cyc%0d", i),  got_cyc[i] - got_cyc[0], i);
         chk($sformatf("bp_data%0d", i), got_dat[i],             32'hDEAD_7FEF);
      end

      // Full FIFO with continuous traffic in both directions
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      k = 0;
      for (int c = 0; c < 10 && k < 4; c++) begin
         req_valid = 1'b1;
         req_tag   = 4'(k);
         @(negedge clk);
         acc = req_ready;
         @(posedge clk); #1;
         if (acc) k++;
      end
      chk("full_fill", k, 4);
      rsp_ready = 1'b1;
      e = 0;
      for (int c = 0; c < 8; c++) begin
         req_valid = 1'b1;
         req_tag   = 4'(k);
         @(negedge clk);
         chk($sformatf("full_flow%0d", c), {rsp_valid, req_ready}, 2'b11);
         chk($sformatf("full_tag%0d", c),  rsp_tag, 4'(e));
         e++;
         acc = req_ready;
         @(posedge clk); #1;
         if (acc) k++;
      end
      req_valid = 1'b0;
      n = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (rsp_valid) n++;
         @(posedge clk); #1;
      end
      chk("full_drain", n, 4);

      // Reset with three loads in flight
      rsp_ready = 1'b0;
      k = 0;
      for (int c = 0; c < 10 && k < 3; c++) begin
         req_valid = 1'b1;
         req_tag   = 4'(k);
         @(negedge clk);
         acc = req_ready;
         @(posedge clk); #1;
         if (acc) k++;
      end
      req_valid = 1'b0;
      chk("mid_issued", k, 3);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      n = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (rsp_valid) n++;
      end
      chk("mid_no_rsp", n, 0);
      v = mk(0, 32'h8000_0010, 4, 0, 32'h0, 4'd7, 32'hDEAD_7FEF, 0);
      send(v, ok);
      chk("mid_accept", ok, 1);
      if (ok) begin
         wait_rsp(lat);
         chk("mid_latency", lat,       RD_LAT);
         chk("mid_rdata",   rsp_rdata, v.exp_rdata);
         chk("mid_tag",     rsp_tag,   v.tag);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
